// File: rtl/prim_sync_reqack_src.sv
// Source endpoint of a two-phase (toggle) req/ack clock-domain crossing: holds a word on
// cdc_data_o, toggles cdc_req_o and waits for the resynchronized ack toggle to match.
module prim_sync_reqack_src #(
  parameter int unsigned      Width         = 16,
  parameter logic [Width-1:0] ResetValue    = {Width{1'b0}},
  parameter int unsigned      TimeoutCycles = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             src_valid_i,
  input  logic [Width-1:0] src_data_i,
  output logic             src_ready_o,
  output logic             done_o,
  output logic             cdc_req_o,
  output logic [Width-1:0] cdc_data_o,
  input  logic             cdc_ack_i,
  output logic             timeout_o,
  output logic             proto_err_o
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  state_e           state_r, state_s;
  logic             ack_q1_r, ack_q2_r;
  logic             req_r, req_s;
  logic [Width-1:0] data_r, data_s;
  logic             done_r, done_s;
  logic             proto_err_r, proto_err_s;
  logic             timeout_r;

  // Two-flop resynchronizer for the asynchronous far-domain ack toggle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q1_r <= 1'b0;
      ack_q2_r <= 1'b0;
    end else begin
      ack_q1_r <= cdc_ack_i;
      ack_q2_r <= ack_q1_r;
    end
  end

  // Next-state, handshake and protocol-error logic
  always_comb begin
    state_s     = state_r;
    req_s       = req_r;
    data_s      = data_r;
    done_s      = 1'b0;
    proto_err_s = proto_err_r;
    case (state_r)
      IDLE: begin
        if (src_valid_i) begin
          req_s   = ~req_r;
          data_s  = src_data_i;
          state_s = WAIT_ACK;
        end else begin
          state_s = IDLE;
        end
        // Matching phases are the only legal idle condition
        if (ack_q2_r != req_r) begin
          proto_err_s = 1'b1;
        end else begin
          proto_err_s = proto_err_r;
        end
      end
      WAIT_ACK: begin
        if (ack_q2_r == req_r) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = WAIT_ACK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control and data registers; the CDC outputs come straight from these flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      req_r       <= 1'b0;
      data_r      <= ResetValue;
      done_r      <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_r       <= req_s;
      data_r      <= data_s;
      done_r      <= done_s;
      proto_err_r <= proto_err_s;
    end
  end

  if (TimeoutCycles > 0) begin : gen_watchdog
    localparam int unsigned     CntW   = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
    logic [CntW-1:0] cnt_r;

    // Saturating WAIT_ACK cycle counter (zero whenever idle) and sticky timeout flag
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_r     <= {CntW{1'b0}};
        timeout_r <= 1'b0;
      end else begin
        if (state_r == IDLE) begin
          cnt_r <= {CntW{1'b0}};
        end else if (cnt_r != CntMax) begin
          cnt_r <= cnt_r + CntW'(1);
        end else begin
          cnt_r <= cnt_r;
        end
        if ((state_r == WAIT_ACK) && (cnt_r == CntMax)) begin
          timeout_r <= 1'b1;
        end else begin
          timeout_r <= timeout_r;
        end
      end
    end
  end else begin : gen_no_watchdog
    assign timeout_r = 1'b0;
  end

  assign src_ready_o = (state_r == IDLE);
  assign done_o      = done_r;
  assign cdc_req_o   = req_r;
  assign cdc_data_o  = data_r;
  assign timeout_o   = timeout_r;
  assign proto_err_o = proto_err_r;

endmodule

// File: tb/tb_prim_sync_reqack_src.sv
// Scoreboard bench for prim_sync_reqack_src: accepted words and expected done edges are queued
// by the stimulus/far-end model and popped by a monitor as the DUT toggles req or pulses done.
module tb_prim_sync_reqack_src;

  logic        clk = 1'b0;
  logic        rst_i, src_valid_i, src_ready_o, done_o, cdc_req_o, cdc_ack_i;
  logic        timeout_o, proto_err_o;
  logic [15:0] src_data_i, cdc_data_o;

  prim_sync_reqack_src #(
    .Width(16), .ResetValue(16'hA5A5), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .src_valid_i(src_valid_i), .src_data_i(src_data_i),
    .src_ready_o(src_ready_o), .done_o(done_o), .cdc_req_o(cdc_req_o), .cdc_data_o(cdc_data_o),
    .cdc_ack_i(cdc_ack_i), .timeout_o(timeout_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0, bad = 0;
  logic [15:0] exp_q[$];
  int          done_q[$];
  bit          busy;
  logic [15:0] held;
  logic        mon_last;
  int          done_cnt = 0;

  bit   far_on, manual_toggle, manual_done, ack_zero;
  int   far_delay, tog_cyc;
  logic far_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever req toggles or done pulses
  initial begin
    mon_last = 1'b0;
    busy     = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_i) begin
        exp_q.delete(); done_q.delete();
        busy = 1'b0; mon_last = 1'b0;
      end else begin
        if (cdc_req_o !== mon_last) begin
          mon_last = cdc_req_o;
          check("req_has_word", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            held = exp_q.pop_front();
            check("data_at_accept", 32'(cdc_data_o), 32'(held));
          end
          check("ready_low_busy", 32'(src_ready_o), 32'd0);
          busy = 1'b1;
        end else if (busy) begin
          check("data_hold", 32'(cdc_data_o), 32'(held));
        end
        if (done_o) begin
          check("done_expected", 32'(done_q.size() > 0), 32'd1);
          if (done_q.size() > 0) check("done_edge", 32'(cyc), 32'(done_q.pop_front()));
          check("ready_with_done", 32'(src_ready_o), 32'd1);
          done_cnt++;
          busy = 1'b0;
        end
      end
    end
  end

  // Far-end model: echoes each req toggle after far_delay cycles; done due 3 edges after toggle
  initial begin
    int pend;
    pend = -1; cdc_ack_i = 1'b0; far_last = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_i) begin
        far_last = 1'b0; pend = -1;
      end else if (cdc_req_o !== far_last) begin
        far_last = cdc_req_o;
        if (far_on) pend = far_delay;
      end
      @(negedge clk);
      if (ack_zero) begin
        cdc_ack_i = 1'b0; ack_zero = 1'b0;
      end else if (manual_toggle) begin
        cdc_ack_i = ~cdc_ack_i; tog_cyc = cyc;
        if (manual_done) done_q.push_back(cyc + 3);
        manual_toggle = 1'b0;
      end else if (pend == 0) begin
        cdc_ack_i = ~cdc_ack_i;
        done_q.push_back(cyc + 3);
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL sim_timeout: actual=running required=finished");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [15:0] w, output int acc);
    int n;
    n = 0;
    src_valid_i = 1'b1;
    while (!src_ready_o && n < 300) begin
      src_data_i = 16'($urandom);
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 32'(src_ready_o), 32'd1);
    src_data_i = w;
    exp_q.push_back(w);
    acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || done_q.size() > 0 || busy || manual_toggle) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < 300), 32'd1);
  endtask

  task automatic at_cyc(input int t);
    do begin
      @(posedge clk); #1;
    end while (cyc < t);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_i = 1'b1; src_valid_i = 1'b0; ack_zero = 1'b1;
    repeat (n) @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    int   acc, d0;
    logic r0;
    rst_i = 1'b1; src_valid_i = 1'b0; src_data_i = 16'h0000;
    far_on = 1'b0; far_delay = 0; manual_toggle = 1'b0; manual_done = 1'b0; ack_zero = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(cdc_data_o), 32'h0000A5A5);
    check("rst_req", 32'(cdc_req_o), 32'd0);
    check("rst_ready", 32'(src_ready_o), 32'd1);
    check("rst_flags", {29'd0, done_o, timeout_o, proto_err_o}, 32'd0);
    rst_i = 1'b0;

    // Single transfer, far end answers 5 cycles after seeing req
    far_on = 1'b1; far_delay = 5; d0 = done_cnt;
    send(16'h1234, acc);
    src_valid_i = 1'b0;
    check("single_req", 32'(cdc_req_o), 32'd1);
    wait_idle();
    check("single_dones", 32'(done_cnt - d0), 32'd1);
    check("single_ready", 32'(src_ready_o), 32'd1);
    check("single_data", 32'(cdc_data_o), 32'h00001234);

    // Back-to-back with valid held high and an immediate responder
    far_delay = 0; d0 = done_cnt; r0 = cdc_req_o;
    for (int k = 1; k <= 3; k++) begin
      send(16'(k), acc);
      check("b2b_req", 32'(cdc_req_o), 32'(r0 ^ k[0]));
    end
    src_valid_i = 1'b0;
    wait_idle();
    check("b2b_dones", 32'(done_cnt - d0), 32'd3);

    // Random words, gaps and far-end delays
    d0 = done_cnt;
    for (int i = 0; i < 25; i++) begin
      far_delay = $urandom_range(0, 4);
      src_valid_i = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(16'($urandom), acc);
    end
    src_valid_i = 1'b0;
    wait_idle();
    check("rand_dones", 32'(done_cnt - d0), 32'd25);
    check("rand_flags", {30'd0, timeout_o, proto_err_o}, 32'd0);

    // Watchdog: ack withheld, data changed while busy, late ack completes
    do_reset(2);
    far_on = 1'b0;
    send(16'hBEEF, acc);
    src_data_i = 16'h0F0F;
    at_cyc(acc + 7);
    check("timeout_early", 32'(timeout_o), 32'd0);
    at_cyc(acc + 9);
    check("timeout_set", 32'(timeout_o), 32'd1);
    at_cyc(acc + 20);
    check("timeout_sticky", 32'(timeout_o), 32'd1);
    check("timeout_busy", 32'(src_ready_o), 32'd0);
    check("busy_data", 32'(cdc_data_o), 32'h0000BEEF);
    @(negedge clk);
    src_valid_i = 1'b0;
    d0 = done_cnt; manual_done = 1'b1; manual_toggle = 1'b1;
    wait_idle();
    check("late_done", 32'(done_cnt - d0), 32'd1);
    check("late_ready", 32'(src_ready_o), 32'd1);
    check("late_timeout", 32'(timeout_o), 32'd1);

    // Ack toggle while idle raises the sticky protocol error, no done pulse
    do_reset(2);
    @(negedge clk);
    check("proto_before", 32'(proto_err_o), 32'd0);
    manual_done = 1'b0; manual_toggle = 1'b1;
    wait_idle();
    at_cyc(tog_cyc + 2);
    check("proto_not_yet", 32'(proto_err_o), 32'd0);
    at_cyc(tog_cyc + 3);
    check("proto_set", 32'(proto_err_o), 32'd1);
    at_cyc(tog_cyc + 8);
    check("proto_sticky", 32'(proto_err_o), 32'd1);

    // Reset during WAIT_ACK drops the transfer and clears flags
    do_reset(2);
    send(16'h5555, acc);
    src_valid_i = 1'b0;
    check("mid_req", 32'(cdc_req_o), 32'd1);
    check("mid_busy", 32'(src_ready_o), 32'd0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready", 32'(src_ready_o), 32'd1);
    check("mid_rst_req", 32'(cdc_req_o), 32'd0);
    check("mid_rst_proto", 32'(proto_err_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_flags", {29'd0, done_o, timeout_o, proto_err_o}, 32'd0);
    check("post_rst_ready", 32'(src_ready_o), 32'd1);
    check("sb_empty", 32'(exp_q.size() + done_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
